// File: rtl/instr_fetch.sv
// Multicycle fetch/sequencing stage: owns the PC, reads instruction words, hands them to the register file.
// Latency: at least 3 cycles per instruction (FETCH, ISSUE, EXEC); each memory wait cycle adds one.
// Backpressure: holds the read request and address stable while mem_waitrequest is high; waits in EXEC for end_instr.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic        active,
  input  logic        end_instr,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        running
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // pending: the instruction now in flight sits in a branch delay slot and
  // saved_target is where the flow goes once it retires.
  logic        pending;
  logic [31:0] saved_target;

  // Branch information collected while the current instruction executes.
  logic        br_seen;
  logic [31:0] tgt;

  logic        at_halt;
  logic        fetch_done;
  logic        retire;
  logic        br_now;
  logic [31:0] tgt_now;

  assign at_halt    = (pc == HALT_ADDR);
  assign fetch_done = (state == FETCH) && !at_halt && !mem_waitrequest;
  assign retire     = (state == EXEC) && end_instr;
  assign br_now     = br_seen || branch_taken;
  // A branch reported in the retire cycle itself wins over an earlier one.
  assign tgt_now    = branch_taken ? branch_target : tgt;

  // Next-state selection and state-decoded outputs.
  always_comb begin
    state_nxt   = state;
    mem_read    = 1'b0;
    active      = 1'b0;
    running     = 1'b1;
    mem_address = pc;
    case (state)
      FETCH: begin
        if (at_halt) begin
          state_nxt = HALTED;
        end else begin
          // Gated by reset so an in-progress read is dropped immediately.
          mem_read = !reset;
          if (!mem_waitrequest) begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        active    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        if (end_instr) begin
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        running = 1'b0;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the instruction word when the memory read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= 32'h0;
    end else if (fetch_done) begin
      instr <= mem_readdata;
    end
  end

  // Collect branch reports during EXEC; a later report overwrites the target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_seen <= 1'b0;
      tgt     <= 32'h0;
    end else if (retire) begin
      br_seen <= 1'b0;
    end else if ((state == EXEC) && branch_taken) begin
      br_seen <= 1'b1;
      tgt     <= branch_target;
    end
  end

  // PC update at retire; a branch taken inside a delay slot is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_VECTOR;
      pending      <= 1'b0;
      saved_target <= 32'h0;
    end else if (retire) begin
      pc           <= pending ? saved_target : (pc + 32'd4);
      pending      <= br_now && !pending;
      saved_target <= tgt_now;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: lockstep randomized driver plus an instruction-level PC model.
// Each cycle the driver publishes the expected outputs; a negedge process compares them.
// Directed sequences cover reset, stalls, delay slots, halt and PC wrap; then a random run follows.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = 32'h0;
  logic [31:0] instr;
  logic        active;
  logic        end_instr = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] pc;
  logic        running;

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata   (mem_readdata),
    .instr          (instr),
    .active         (active),
    .end_instr      (end_instr),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .pc             (pc),
    .running        (running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction-level model of the sequencer.
  logic [31:0] m_pc      = 32'hBFC00000;
  logic        m_pending = 1'b0;
  logic [31:0] m_saved   = 32'h0;
  logic        m_halted  = 1'b0;
  logic [31:0] m_instr   = 32'h0;

  // Expected outputs for the current cycle.
  bit          chk_en = 1'b0;
  logic        exp_mem_read = 1'b0;
  logic        exp_active = 1'b0;
  logic        exp_running = 1'b1;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_instr = 32'h0;

  int rd_cnt = 0;
  int act_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the published expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_read", {31'h0, mem_read}, {31'h0, exp_mem_read});
      chk("active", {31'h0, active}, {31'h0, exp_active});
      chk("running", {31'h0, running}, {31'h0, exp_running});
      chk("pc", pc, exp_pc);
      chk("mem_address", mem_address, exp_pc);
      chk("instr", instr, exp_instr);
      if (mem_read) rd_cnt++;
      if (active) act_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_noise();
    mem_waitrequest = ($urandom % 2) == 0;
    mem_readdata    = $urandom;
    end_instr       = ($urandom % 4) == 0;
    branch_taken    = ($urandom % 4) == 0;
    branch_target   = $urandom;
  endtask

  task automatic do_reset();
    chk_en        = 1'b0;
    end_instr     = 1'b0;
    branch_taken  = 1'b0;
    reset         = 1'b1;
    #1;
    chk("rst pc", pc, 32'hBFC00000);
    chk("rst active", {31'h0, active}, 32'h0);
    chk("rst running", {31'h0, running}, 32'h1);
    chk("rst mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst instr", instr, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    m_pc      = 32'hBFC00000;
    m_pending = 1'b0;
    m_saved   = 32'h0;
    m_halted  = 1'b0;
    m_instr   = 32'h0;
    exp_instr = 32'h0;
    chk_en    = 1'b1;
  endtask

  task automatic do_halted(input int n);
    for (int i = 0; i < n; i++) begin
      set_noise();
      exp_mem_read = 1'b0;
      exp_active   = 1'b0;
      exp_running  = 1'b0;
      exp_pc       = m_pc;
      cyc();
    end
  endtask

  // One instruction: w wait cycles, e EXEC cycles, nbr branch reports (t1 then t2).
  task automatic do_instr(input int w, input logic [31:0] data, input int e, input int nbr,
                          input logic [31:0] t1, input logic [31:0] t2, input bit abort);
    int p1, p2;
    bit br;
    logic [31:0] tg;
    if (m_pc == 32'h0) begin
      set_noise();
      exp_mem_read = 1'b0;
      exp_active   = 1'b0;
      exp_running  = 1'b1;
      exp_pc       = m_pc;
      cyc();
      m_halted = 1'b1;
      return;
    end
    for (int i = 0; i <= w; i++) begin
      set_noise();
      mem_waitrequest = (i < w);
      mem_readdata    = (i < w) ? $urandom : data;
      exp_mem_read    = 1'b1;
      exp_active      = 1'b0;
      exp_running     = 1'b1;
      exp_pc          = m_pc;
      cyc();
    end
    set_noise();
    m_instr      = data;
    exp_instr    = data;
    exp_mem_read = 1'b0;
    exp_active   = 1'b1;
    cyc();
    if (nbr == 2 && e < 2) e = 2;
    p1 = (nbr == 2) ? $urandom_range(0, e - 2) : $urandom_range(0, e - 1);
    p2 = (nbr == 2) ? $urandom_range(p1 + 1, e - 1) : -1;
    br = 1'b0;
    tg = 32'h0;
    for (int j = 0; j < e; j++) begin
      mem_waitrequest = ($urandom % 2) == 0;
      mem_readdata    = $urandom;
      end_instr       = (j == e - 1) && !abort;
      branch_taken    = 1'b0;
      branch_target   = $urandom;
      if (nbr >= 1 && j == p1) begin
        branch_taken = 1'b1; branch_target = t1; br = 1'b1; tg = t1;
      end
      if (nbr == 2 && j == p2) begin
        branch_taken = 1'b1; branch_target = t2; br = 1'b1; tg = t2;
      end
      exp_active = 1'b0;
      cyc();
    end
    if (!abort) begin
      // Delay slot: the instruction after a branch always executes, then flow jumps.
      logic [31:0] nxt;
      nxt = m_pending ? m_saved : (m_pc + 32'd4);
      if (m_pending) begin
        m_pending = 1'b0;
      end else if (br) begin
        m_pending = 1'b1;
        m_saved   = tg;
      end
      m_pc = nxt;
    end
  endtask

  function automatic logic [31:0] rnd_target();
    int r;
    logic [31:0] v;
    r = $urandom_range(0, 19);
    v = $urandom;
    if (r == 0) return 32'h0;
    if (r == 1) return 32'hFFFFFFF8;
    return {v[31:2], 2'b00};
  endfunction

  initial begin
    #2;
    do_reset();

    // Stalled fetch followed by a sequential instruction.
    rd_cnt  = 0;
    act_cnt = 0;
    do_instr(3, 32'h8C220004, 2, 0, 32'h0, 32'h0, 1'b0);
    chk("T2 read cycles", rd_cnt, 4);
    chk("T2 active cycles", act_cnt, 1);
    chk("T2 instr", instr, 32'h8C220004);
    chk("T3 next addr", mem_address, 32'hBFC00004);
    do_instr(0, $urandom, 2, 0, 32'h0, 32'h0, 1'b0);
    chk("T3 seq addr", mem_address, 32'hBFC00008);

    // Branch with delay slot.
    do_instr(1, $urandom, 2, 1, 32'hBFC00100, 32'h0, 1'b0);
    chk("T4 slot addr", mem_address, 32'hBFC0000C);
    do_instr(0, $urandom, 1, 0, 32'h0, 32'h0, 1'b0);
    chk("T4 target addr", mem_address, 32'hBFC00100);

    // Reset while executing.
    do_instr(0, $urandom, 3, 0, 32'h0, 32'h0, 1'b1);
    do_reset();

    // Jump to address 0 halts after the delay slot.
    for (int k = 0; k < 4; k++) do_instr($urandom_range(0, 2), $urandom, $urandom_range(1, 3), 0, 32'h0, 32'h0, 1'b0);
    chk("T5 branch pc", pc, 32'hBFC00010);
    do_instr(0, $urandom, 2, 1, 32'h0, 32'h0, 1'b0);
    chk("T5 slot pc", pc, 32'hBFC00014);
    do_instr(0, $urandom, 1, 0, 32'h0, 32'h0, 1'b0);
    chk("T5 halt pc", pc, 32'h0);
    do_instr(0, $urandom, 1, 0, 32'h0, 32'h0, 1'b0);
    do_halted(6);
    chk("T5 running", {31'h0, running}, 32'h0);
    chk("T5 mem_read", {31'h0, mem_read}, 32'h0);

    // Branch in a delay slot is ignored; PC wraps to 0 and halts.
    do_reset();
    do_instr(0, $urandom, 2, 1, 32'hBFC00200, 32'h0, 1'b0);
    do_instr(0, $urandom, 2, 1, 32'hBFC00300, 32'h0, 1'b0);
    chk("T6 target A", mem_address, 32'hBFC00200);
    do_instr(0, $urandom, 3, 2, 32'h12345678, 32'hFFFFFFFC, 1'b0);
    do_instr(0, $urandom, 1, 0, 32'h0, 32'h0, 1'b0);
    chk("T6 wrap start", pc, 32'hFFFFFFFC);
    do_instr(2, $urandom, 1, 0, 32'h0, 32'h0, 1'b0);
    chk("T6 wrapped", pc, 32'h0);
    do_instr(0, $urandom, 1, 0, 32'h0, 32'h0, 1'b0);
    do_halted(3);
    chk("T6 running", {31'h0, running}, 32'h0);

    // Randomized run.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_halted) begin
        do_halted($urandom_range(1, 4));
        do_reset();
      end else if ($urandom_range(0, 49) == 0) begin
        do_instr($urandom_range(0, 2), $urandom, $urandom_range(1, 3), 0, 32'h0, 32'h0, 1'b1);
        do_reset();
      end else begin
        int r;
        int nb;
        r  = $urandom_range(0, 9);
        nb = (r < 6) ? 0 : ((r < 9) ? 1 : 2);
        do_instr($urandom_range(0, 3), $urandom, $urandom_range(1, 4), nb,
                 rnd_target(), rnd_target(), 1'b0);
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
